// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle RV32 control FSM with wait states, traps, interrupts and counters
module mc_ctrl_fsm #(
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter bit          EXT_EN        = 1'b1,
    parameter bit          OVF_TRAP      = 1'b1,
    parameter bit          IRQ_EN        = 1'b1,
    parameter logic [31:0] IRQ_CAUSE     = 32'h8000_0003,
    parameter int          CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic [11:0]      sys_imm,
    input  logic             Zero,
    input  logic             Overflow,
    input  logic             mem_ready,
    input  logic             irq,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUControl,
    output logic             CauseWrite,
    output logic [31:0]      cause_code,
    output logic             Trap,
    output logic             TrapRd31,
    output logic             PcFromEpc,
    output logic             is_jalr,
    output logic             Halt,
    output logic             irq_masked,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);
    typedef enum logic [3:0] {
        S_IF = 4'd0, S_ID = 4'd1, S_EX_ALU = 4'd2, S_EX_BR = 4'd3, S_BR_TAKE = 4'd4,
        S_EX_JAL = 4'd5, S_JUMP = 4'd6, S_WB_ALU = 4'd7, S_MEM_RD = 4'd8, S_MEM_WR = 4'd9,
        S_WB_MEM = 4'd10, S_TRAP = 4'd11, S_TRAP_WB = 4'd12, S_MRET = 4'd13, S_HALTED = 4'd14
    } state_t;

    localparam logic [6:0] OP_R    = 7'h33;
    localparam logic [6:0] OP_ADDI = 7'h13;
    localparam logic [6:0] OP_LW   = 7'h03;
    localparam logic [6:0] OP_SW   = 7'h23;
    localparam logic [6:0] OP_LUI  = 7'h37;
    localparam logic [6:0] OP_BR   = 7'h63;
    localparam logic [6:0] OP_JAL  = 7'h6f;
    localparam logic [6:0] OP_JALR = 7'h67;
    localparam logic [6:0] OP_SYS  = 7'h73;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [31:0]      cause_q, cause_d;
    logic             irq_masked_q, irq_masked_d;
    logic [CNT_W-1:0] cycle_q, cycle_d, instret_q, instret_d;

    logic       ready, irq_take, retire;
    logic       r_legal, is_alu, is_br, is_jump, is_ecall, is_mret, is_addsub;
    logic [2:0] r_op;

    assign ready    = MEM_HANDSHAKE ? mem_ready : 1'b1;
    // Gated by reset so the held-in-reset outputs always show a plain fetch.
    assign irq_take = IRQ_EN && irq && !irq_masked_q && !reset;

    always_comb begin
        r_legal = 1'b1;
        r_op    = ALU_ADD;
        case (funct3)
            3'b000:  r_op = funct7_5 ? ALU_SUB : ALU_ADD;
            3'b110:  begin r_op = ALU_OR;  r_legal = !funct7_5; end
            3'b111:  begin r_op = ALU_AND; r_legal = EXT_EN && !funct7_5; end
            3'b010:  begin r_op = ALU_SLT; r_legal = EXT_EN && !funct7_5; end
            default: r_legal = 1'b0;
        endcase
    end

    assign is_alu    = (opcode == OP_R && r_legal) || (opcode == OP_ADDI && funct3 == 3'b000)
                     || ((opcode == OP_LW || opcode == OP_SW) && funct3 == 3'b010) || opcode == OP_LUI;
    assign is_br     = opcode == OP_BR && (funct3 == 3'b000 || (EXT_EN && funct3 == 3'b001));
    assign is_jump   = opcode == OP_JAL || (opcode == OP_JALR && funct3 == 3'b000);
    assign is_ecall  = opcode == OP_SYS && funct3 == 3'b000 && sys_imm == 12'h000;
    assign is_mret   = opcode == OP_SYS && funct3 == 3'b000 && sys_imm == 12'h302;
    assign is_addsub = opcode == OP_ADDI || (opcode == OP_R && funct3 == 3'b000);

    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        irq_masked_d = irq_masked_q;
        cycle_d      = (state_q == S_HALTED) ? cycle_q : cycle_q + CNT_ONE;
        instret_d    = instret_q;
        retire       = 1'b0;
        PCWrite = 1'b0; IRWrite = 1'b0; RegWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        MemtoReg = 1'b0; ALUSrcA = 2'b01; ALUSrcB = 2'b00; ALUControl = ALU_ADD;
        CauseWrite = 1'b0; cause_code = 32'd0; Trap = 1'b0; TrapRd31 = 1'b0;
        PcFromEpc = 1'b0; is_jalr = 1'b0; Halt = 1'b0;
        case (state_q)
            S_IF: begin
                if (irq_take) begin
                    state_d = S_TRAP;
                    cause_d = IRQ_CAUSE;
                end else begin
                    MemRead = 1'b1; ALUSrcA = 2'b00; ALUSrcB = 2'b10;
                    IRWrite = ready; PCWrite = ready;
                    if (ready) state_d = S_ID;
                end
            end
            S_ID: begin
                if (is_alu)        state_d = S_EX_ALU;
                else if (is_br)    state_d = S_EX_BR;
                else if (is_jump)  state_d = S_EX_JAL;
                else if (is_ecall) state_d = S_HALTED;
                else if (is_mret)  state_d = S_MRET;
                else begin
                    state_d = S_TRAP;
                    cause_d = 32'd1;
                end
            end
            S_EX_ALU: begin
                if (opcode == OP_LUI) begin
                    ALUSrcA = 2'b10; ALUSrcB = 2'b01;
                end else if (opcode == OP_R) begin
                    ALUControl = r_op;
                end else begin
                    ALUSrcB = 2'b01;
                end
                if (OVF_TRAP && Overflow && is_addsub) begin
                    state_d = S_TRAP;
                    cause_d = 32'd2;
                end else if (opcode == OP_LW) state_d = S_MEM_RD;
                else if (opcode == OP_SW)     state_d = S_MEM_WR;
                else                          state_d = S_WB_ALU;
            end
            S_EX_BR: begin
                ALUControl = ALU_SUB;
                // funct3[0] distinguishes BNE from BEQ, inverting the Zero sense.
                if (Zero ^ funct3[0]) state_d = S_BR_TAKE;
                else begin state_d = S_IF; retire = 1'b1; end
            end
            S_BR_TAKE: begin
                ALUSrcA = 2'b11; ALUSrcB = 2'b01; PCWrite = 1'b1;
                state_d = S_IF; retire = 1'b1;
            end
            S_EX_JAL: begin
                ALUSrcA = 2'b11; ALUSrcB = 2'b10;
                state_d = S_JUMP;
            end
            S_JUMP: begin
                PCWrite = 1'b1; RegWrite = 1'b1; ALUSrcB = 2'b01;
                if (opcode == OP_JALR) is_jalr = 1'b1;
                else                   ALUSrcA = 2'b11;
                state_d = S_IF; retire = 1'b1;
            end
            S_WB_ALU: begin
                RegWrite = 1'b1;
                state_d = S_IF; retire = 1'b1;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                if (ready) state_d = S_WB_MEM;
            end
            S_WB_MEM: begin
                RegWrite = 1'b1; MemtoReg = 1'b1;
                state_d = S_IF; retire = 1'b1;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                if (ready) begin state_d = S_IF; retire = 1'b1; end
            end
            S_TRAP: begin
                CauseWrite = 1'b1; cause_code = cause_q; Trap = 1'b1;
                // An interrupt saves the un-fetched PC; a fault saves the next instruction.
                if (cause_q == IRQ_CAUSE) begin ALUSrcA = 2'b00; ALUSrcB = 2'b11; end
                else                      begin ALUSrcA = 2'b11; ALUSrcB = 2'b10; end
                irq_masked_d = 1'b1;
                state_d = S_TRAP_WB;
            end
            S_TRAP_WB: begin
                RegWrite = 1'b1; TrapRd31 = 1'b1;
                state_d = S_IF;
            end
            S_MRET: begin
                PCWrite = 1'b1; PcFromEpc = 1'b1;
                irq_masked_d = 1'b0;
                state_d = S_IF; retire = 1'b1;
            end
            S_HALTED: Halt = 1'b1;
            default:  state_d = S_IF;
        endcase
        if (retire) instret_d = instret_q + CNT_ONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IF;
            cause_q      <= 32'd0;
            irq_masked_q <= 1'b0;
            cycle_q      <= '0;
            instret_q    <= '0;
        end else begin
            state_q      <= state_d;
            cause_q      <= cause_d;
            irq_masked_q <= irq_masked_d;
            cycle_q      <= cycle_d;
            instret_q    <= instret_d;
        end
    end

    assign irq_masked  = irq_masked_q;
    assign state_o     = state_q;
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
endmodule
